fifo_ctrl: RTL and testbench

Pointer and flag controller for the team's small synchronous FIFO. It owns the read/write pointers of a 2^AW-entry register-file buffer and arbitrates write and read requests against full/empty. It drives the buffer's write strobe and addresses, and reports occupancy and error pulses. It sits between the producer/consumer handshake and the storage array, and uses the same per-bit XNOR/AND equality structure for its pointer-address compare.

---
 rtl/fifo_ctrl_if.sv | 24 ++
 rtl/fifo_ctrl.sv | 60 ++++++
 tb/tb_fifo_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Handshake and storage-control bundle between the FIFO pointer controller and its users.
// The master side raises push/pop requests; the slave side (fifo_ctrl) drives the strobe, addresses and flags.
interface fifo_ctrl_if #(parameter int AW = 2);
    logic          wr_req;
    logic          rd_req;
    logic          mem_we;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr_req, rd_req,
        input  mem_we, wr_addr, rd_addr, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req,
        output mem_we, wr_addr, rd_addr, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Read/write pointer and flag controller for a 2^AW-entry register-file FIFO.
// Pointers carry an extra wrap bit so full and empty are told apart by one address compare.
module fifo_ctrl #(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_q;

    logic addr_eq;
    logic wrap_eq;
    logic full_c;
    logic empty_c;
    logic do_wr;
    logic do_rd;

    // Per-bit XNOR reduced by AND, matching the buffer's own equality structure.
    always_comb begin
        addr_eq = &(~(wr_ptr[AW-1:0] ^ rd_ptr[AW-1:0]));
        wrap_eq = ~(wr_ptr[AW] ^ rd_ptr[AW]);
        empty_c = addr_eq & wrap_eq;
        full_c  = addr_eq & ~wrap_eq;
        // A push into a full FIFO is allowed when the head leaves in the same cycle.
        do_wr   = bus.wr_req & (~full_c | bus.rd_req);
        do_rd   = bus.rd_req & ~empty_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr <= wr_ptr + (do_wr ? PTR_ONE : '0);
            rd_ptr <= rd_ptr + (do_rd ? PTR_ONE : '0);
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.mem_we    = do_wr;
    assign bus.wr_addr   = wr_ptr[AW-1:0];
    assign bus.rd_addr   = rd_ptr[AW-1:0];
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.count     = count_q;
    assign bus.overflow  = bus.wr_req & full_c & ~bus.rd_req;
    assign bus.underflow = bus.rd_req & empty_c;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an occupancy/total-count model.
module tb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    fifo_ctrl_if #(.AW(AW)) bus ();

    fifo_ctrl #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    int  occ      = 0;
    int  wrTotal  = 0;
    int  rdTotal  = 0;
    bit  modelOk  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r);
        bus.wr_req = w;
        bus.rd_req = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: occupancy plus running totals of accepted pushes and pops.
    always @(negedge clk) begin
        bit w, r, acceptWr, acceptRd;
        w = (bus.wr_req === 1'b1);
        r = (bus.rd_req === 1'b1);
        acceptWr = w && (occ < DEPTH || r);
        acceptRd = r && (occ > 0);
        if (modelOk) begin
            checkOutput("empty",     32'(bus.empty),     32'(occ == 0));
            checkOutput("full",      32'(bus.full),      32'(occ == DEPTH));
            checkOutput("count",     32'(bus.count),     32'(occ));
            checkOutput("wr_addr",   32'(bus.wr_addr),   32'(wrTotal % DEPTH));
            checkOutput("rd_addr",   32'(bus.rd_addr),   32'(rdTotal % DEPTH));
            checkOutput("mem_we",    32'(bus.mem_we),    32'(acceptWr));
            checkOutput("overflow",  32'(bus.overflow),  32'(w && !r && occ == DEPTH));
            checkOutput("underflow", 32'(bus.underflow), 32'(r && occ == 0));
        end
        if (rst === 1'b1) begin
            occ     = 0;
            wrTotal = 0;
            rdTotal = 0;
            modelOk = 1;
        end else if (modelOk) begin
            if (acceptWr) wrTotal = (wrTotal + 1) % (2 * DEPTH);
            if (acceptRd) rdTotal = (rdTotal + 1) % (2 * DEPTH);
            occ = occ + int'(acceptWr) - int'(acceptRd);
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        repeat (3) tick();
        checkOutput("lit_reset_empty",   32'(bus.empty),     32'd1);
        checkOutput("lit_reset_full",    32'(bus.full),      32'd0);
        checkOutput("lit_reset_count",   32'(bus.count),     32'd0);
        checkOutput("lit_reset_wr_addr", 32'(bus.wr_addr),   32'd0);
        checkOutput("lit_reset_rd_addr", 32'(bus.rd_addr),   32'd0);
        checkOutput("lit_reset_ovf",     32'(bus.overflow),  32'd0);
        checkOutput("lit_reset_unf",     32'(bus.underflow), 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("lit_fill_we",   32'(bus.mem_we),  32'd1);
            checkOutput("lit_fill_addr", 32'(bus.wr_addr), 32'(i));
            tick();
            checkOutput("lit_fill_count", 32'(bus.count), 32'(i + 1));
        end
        checkOutput("lit_full_after4", 32'(bus.full), 32'd1);

        applyStimulus(1'b1, 1'b0);
        checkOutput("lit_ovf_pulse", 32'(bus.overflow), 32'd1);
        checkOutput("lit_ovf_no_we", 32'(bus.mem_we),   32'd0);
        tick();
        checkOutput("lit_ovf_count", 32'(bus.count), 32'd4);

        applyStimulus(1'b1, 1'b1);
        checkOutput("lit_both_full_we",   32'(bus.mem_we),   32'd1);
        checkOutput("lit_both_full_addr", 32'(bus.wr_addr),  32'd0);
        checkOutput("lit_both_full_ovf",  32'(bus.overflow), 32'd0);
        tick();
        checkOutput("lit_both_full_rd_addr", 32'(bus.rd_addr), 32'd1);
        checkOutput("lit_both_full_count",   32'(bus.count),   32'd4);
        checkOutput("lit_both_full_full",    32'(bus.full),    32'd1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            tick();
        end
        checkOutput("lit_drained_empty", 32'(bus.empty), 32'd1);

        applyStimulus(1'b0, 1'b1);
        checkOutput("lit_unf_pulse", 32'(bus.underflow), 32'd1);
        tick();
        checkOutput("lit_unf_rd_addr", 32'(bus.rd_addr), 32'd1);
        checkOutput("lit_unf_count",   32'(bus.count),   32'd0);

        applyStimulus(1'b1, 1'b1);
        checkOutput("lit_both_empty_we",  32'(bus.mem_we),    32'd1);
        checkOutput("lit_both_empty_unf", 32'(bus.underflow), 32'd1);
        tick();
        checkOutput("lit_both_empty_count", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 1'b1);
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            tick();
            applyStimulus(1'b0, 1'b1);
            tick();
        end
        checkOutput("lit_wrap_empty",   32'(bus.empty),   32'd1);
        checkOutput("lit_wrap_count",   32'(bus.count),   32'd0);
        checkOutput("lit_wrap_wr_addr", 32'(bus.wr_addr), 32'd0);
        checkOutput("lit_wrap_rd_addr", 32'(bus.rd_addr), 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            tick();
        end
        checkOutput("lit_pre_rst_count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("lit_rst_count",   32'(bus.count),   32'd0);
        checkOutput("lit_rst_empty",   32'(bus.empty),   32'd1);
        checkOutput("lit_rst_wr_addr", 32'(bus.wr_addr), 32'd0);

        // Alternate push-heavy and pop-heavy phases so both full and empty are visited often.
        for (int i = 0; i < 1500; i++) begin
            int pw;
            pw  = ((i / 60) % 2 == 0) ? 75 : 30;
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw));
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
